// File: rtl/tt_sweep_capture.sv
// tt_sweep_capture
// ----------------
// Characterisation wrapper for an N_IN-input, single-output function block.
// A sweep drives x through every minterm 0..2**N_IN-1, captures the
// function's answer into a truth table, counts its ones, and then streams
// the table out as hex nibbles, most significant nibble first.
//
// Ports
//   clk, rst     : single rising-edge clock, synchronous active-high reset
//   start        : begin a sweep (only acted on while idle)
//   x            : registered minterm index driven to the function block
//   f_in         : function output, valid PIPE_LAT cycles after x
//   busy         : high whenever the block is not idle
//   done         : one-cycle pulse after the last nibble is accepted
//   tt, tt_valid : captured table (tt[i] = f(i)) and its completion flag
//   ones         : popcount of tt, 0..2**N_IN
//   hex_valid / hex_ready / hex_nibble / hex_last : nibble stream
//   dbg_state    : current FSM state, for observation only
//
// Stream handshake: a nibble transfers on a rising edge where hex_valid and
// hex_ready are both high. While hex_valid is high and hex_ready is low,
// hex_nibble and hex_last hold their values; hex_valid never drops without
// a transfer. hex_ready may toggle freely and is ignored when hex_valid is low.
module tt_sweep_capture #(
  parameter int N_IN     = 7,
  parameter int PIPE_LAT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  output logic [N_IN-1:0]        x,
  input  logic                   f_in,
  output logic                   busy,
  output logic                   done,
  output logic [(1<<N_IN)-1:0]   tt,
  output logic                   tt_valid,
  output logic [N_IN:0]          ones,
  output logic                   hex_valid,
  input  logic                   hex_ready,
  output logic [3:0]             hex_nibble,
  output logic                   hex_last,
  output logic [2:0]             dbg_state
);

  localparam int DEPTH = 1 << N_IN;
  localparam int KW    = N_IN - 2;   // nibble index width

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWEEP = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EMIT  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [N_IN-1:0] X_LAST = '1;
  localparam logic [N_IN-1:0] X_ONE  = 1;
  localparam logic [N_IN:0]   C_ONE  = 1;
  localparam logic [KW-1:0]   K_LAST = '1;
  localparam logic [KW-1:0]   K_ONE  = 1;

  logic [2:0]       state_q, state_d;
  logic [N_IN-1:0]  x_q, x_d;
  logic [N_IN:0]    c_q, c_d;      // capture counter, reaches DEPTH
  logic [KW-1:0]    k_q, k_d;      // nibble index
  logic [DEPTH-1:0] tt_q, tt_d;
  logic [N_IN:0]    ones_q, ones_d;
  logic             tt_valid_q, tt_valid_d;

  // cap_v is high in the cycle where f_in belongs to the next index to store
  logic cap_v;

  generate
    if (PIPE_LAT == 0) begin : g_nolat
      // f_in is combinational from x, so every SWEEP cycle carries a sample.
      assign cap_v = (state_q == S_SWEEP);
    end else begin : g_lat
      // One bit per pipeline stage of the function block: a 1 enters for
      // each cycle x carries a fresh index and falls out as its result lands.
      logic [PIPE_LAT-1:0] vld_q, vld_d;

      always_comb begin
        vld_d    = vld_q << 1;
        vld_d[0] = (state_q == S_SWEEP);
      end

      always_ff @(posedge clk) begin
        if (rst) vld_q <= '0;
        else     vld_q <= vld_d;
      end

      assign cap_v = vld_q[PIPE_LAT-1];
    end
  endgenerate

  logic cap_fire, last_cap;
  assign cap_fire = ((state_q == S_SWEEP) || (state_q == S_DRAIN)) && cap_v && !c_q[N_IN];
  assign last_cap = cap_fire && (c_q[N_IN-1:0] == X_LAST);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    c_d        = c_q;
    k_d        = k_q;
    tt_d       = tt_q;
    ones_d     = ones_q;
    tt_valid_d = tt_valid_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          tt_d       = '0;
          ones_d     = '0;
          tt_valid_d = 1'b0;
          x_d        = '0;
          c_d        = '0;
          k_d        = '0;
          state_d    = S_SWEEP;
        end
      end
      S_SWEEP: begin
        // x stays at the last index once the sweep has been presented
        if (x_q == X_LAST) state_d = (PIPE_LAT > 0) ? S_DRAIN : S_EMIT;
        else               x_d     = x_q + X_ONE;
      end
      S_DRAIN: begin
        // The final capture marks the end of the pipeline flush, which is
        // exactly PIPE_LAT cycles after the last index was driven.
        if (last_cap) state_d = S_EMIT;
      end
      S_EMIT: begin
        if (hex_ready) begin
          if (k_q == K_LAST) state_d = S_DONE;
          else               k_d     = k_q + K_ONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (cap_fire) begin
      tt_d[c_q[N_IN-1:0]] = f_in;
      ones_d              = ones_q + {{N_IN{1'b0}}, f_in};
      c_d                 = c_q + C_ONE;
      if (last_cap) tt_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      x_q        <= '0;
      c_q        <= '0;
      k_q        <= '0;
      tt_q       <= '0;
      ones_q     <= '0;
      tt_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      c_q        <= c_d;
      k_q        <= k_d;
      tt_q       <= tt_d;
      ones_q     <= ones_d;
      tt_valid_q <= tt_valid_d;
    end
  end

  // Nibble k covers tt[DEPTH-1-4k -: 4], so the stream reads the table like
  // its hex name, left to right.
  logic [N_IN-1:0] nib_base;
  assign nib_base = X_LAST - {k_q, 2'b00};

  assign x          = x_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign tt         = tt_q;
  assign tt_valid   = tt_valid_q;
  assign ones       = ones_q;
  assign hex_valid  = (state_q == S_EMIT);
  assign hex_nibble = hex_valid ? tt_q[nib_base -: 4] : 4'h0;
  assign hex_last   = hex_valid && (k_q == K_LAST);
  assign dbg_state  = state_q;

endmodule
